axil_cmd_master: RTL and testbench

- AXI4-Lite initiator (master) that turns a simple single-outstanding command/response interface into AXI-Lite write and read transactions.
- Host-side logic, or a sequencer, uses it to drive the accelerator's register file: {last, run, matw} at 0x000 and the control register at 0x010.
- One transaction in flight at a time; AW and W channels complete independently; responses are held until consumed.
- Includes a sticky watchdog flag for a responder that never answers.

---
 rtl/axil_cmd_master_if.sv | 39 +++
 rtl/axil_cmd_master.sv | 168 ++++++++++++++++
 tb/tb_axil_cmd_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and its register-file responder.
// The master drives addresses, data and the response READYs; the slave drives the rest.
interface axil_cmd_master_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] M_AXI_AWADDR;
   logic              M_AXI_AWVALID;
   logic              M_AXI_AWREADY;
   logic [31:0]       M_AXI_WDATA;
   logic [3:0]        M_AXI_WSTRB;
   logic              M_AXI_WVALID;
   logic              M_AXI_WREADY;
   logic [1:0]        M_AXI_BRESP;
   logic              M_AXI_BVALID;
   logic              M_AXI_BREADY;
   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;
   logic [31:0]       M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
   );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI-Lite transaction out,
// one held response back. Sticky watchdog flags a responder that stalls too long.
module axil_cmd_master #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              M_AXI_ACLK,
   input  logic              M_AXI_ARESETN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              busy,
   output logic              timeout,
   axil_cmd_master_if.master m_axi
);

   typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        wstrb;
   } cmd_t;

   typedef struct packed {
      logic        write;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } rsp_t;

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic            started;
   cmd_t            cmd_q;
   rsp_t            rsp_q;
   logic            rsp_valid_q;
   logic            aw_done, w_done;
   logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic            timeout_q;
   logic [WD_W-1:0] wd_cnt;
   logic            wait_st;
   logic            aw_hs, w_hs;

   assign wait_st = (state == WR) || (state == WB) || (state == RA) || (state == RD);
   assign aw_hs   = awvalid_q & m_axi.M_AXI_AWREADY;
   assign w_hs    = wvalid_q  & m_axi.M_AXI_WREADY;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state       <= IDLE;
         started     <= 1'b0;
         cmd_q       <= '0;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         timeout_q   <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         started <= 1'b1;

         // Watchdog only observes; the transaction keeps waiting after it fires.
         if (wait_st && wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
         if (wait_st && wd_cnt == WD_LAST) timeout_q <= 1'b1;

         case (state)
            IDLE: begin
               if (cmd_valid && started) begin
                  cmd_q  <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
                  wd_cnt <= '0;
                  if (cmd_write) begin
                     state     <= WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                  end else begin
                     state     <= RA;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WR: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state    <= WB;
                  bready_q <= 1'b1;
                  wd_cnt   <= '0;
               end
            end
            WB: begin
               if (m_axi.M_AXI_BVALID && bready_q) begin
                  rsp_q       <= '{write: 1'b1, rdata: 32'h0, resp: m_axi.M_AXI_BRESP};
                  rsp_valid_q <= 1'b1;
                  bready_q    <= 1'b0;
                  state       <= RSP;
               end
            end
            RA: begin
               if (arvalid_q && m_axi.M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  wd_cnt    <= '0;
                  state     <= RD;
               end
            end
            RD: begin
               if (m_axi.M_AXI_RVALID && rready_q) begin
                  rsp_q       <= '{write: 1'b0, rdata: m_axi.M_AXI_RDATA, resp: m_axi.M_AXI_RRESP};
                  rsp_valid_q <= 1'b1;
                  rready_q    <= 1'b0;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = started && (state == IDLE);
   assign busy      = (state != IDLE);
   assign timeout   = timeout_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_q.write;
   assign rsp_rdata = rsp_q.rdata;
   assign rsp_resp  = rsp_q.resp;

   assign m_axi.M_AXI_AWADDR  = cmd_q.addr;
   assign m_axi.M_AXI_AWVALID = awvalid_q;
   assign m_axi.M_AXI_WDATA   = cmd_q.wdata;
   assign m_axi.M_AXI_WSTRB   = cmd_q.wstrb;
   assign m_axi.M_AXI_WVALID  = wvalid_q;
   assign m_axi.M_AXI_BREADY  = bready_q;
   assign m_axi.M_AXI_ARADDR  = cmd_q.addr;
   assign m_axi.M_AXI_ARVALID = arvalid_q;
   assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a cycle-stepped responder with per-channel delays, and an
// expectation model built from handshake cycle numbers and wait-phase lengths.
module tb_axil_cmd_master;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        busy, timeout;

   axil_cmd_master_if #(.ADDR_W(32)) bus ();

   axil_cmd_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
      .m_axi(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID  = 1'b0; bus.M_AXI_BRESP  = 2'b00;
      bus.M_AXI_RVALID  = 1'b0; bus.M_AXI_RRESP  = 2'b00; bus.M_AXI_RDATA = 32'h0;
   endtask

   // One full transaction from an idle negedge. Handshake at cycle k completes on the
   // posedge ending cycle k; a_dly/w_dly hold the address/data READY low that many cycles,
   // r_dly delays B/R after the last address-side handshake, hold delays rsp_ready.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int a_dly, input int w_dly,
                          input int r_dly, input logic [1:0] resp, input logic [31:0] rdata,
                          input int hold, input bit junk, output int rsp_k);
      int  k, aw_hs, w_hs, r_hs, rsp_hs, ph, prev_ph, ph_cnt, last_hs;
      bit  fin, addr_done;
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_timeout", 32'(timeout), 32'(exp_to));
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
      rsp_ready = 1'b0;
      aw_hs = -1; w_hs = -1; r_hs = -1; rsp_hs = -1; rsp_k = -1;
      prev_ph = 0; ph_cnt = 0; k = 0; fin = 1'b0;
      while (!fin && k < 100) begin
         @(negedge clk);
         k++;
         if (rsp_hs >= 0) begin
            chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("post_timeout", 32'(timeout), 32'(exp_to));
            fin = 1'b1;
         end else begin
            addr_done = wr ? (aw_hs >= 0 && w_hs >= 0) : (aw_hs >= 0);
            last_hs   = (wr && w_hs > aw_hs) ? w_hs : aw_hs;
            ph        = !addr_done ? 1 : (r_hs < 0 ? 2 : 0);
            chk("busy", 32'(busy), 32'd1);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            chk("timeout", 32'(timeout), 32'(exp_to));
            chk("awvalid", 32'(bus.M_AXI_AWVALID), 32'(wr && aw_hs < 0));
            chk("wvalid", 32'(bus.M_AXI_WVALID), 32'(wr && w_hs < 0));
            chk("arvalid", 32'(bus.M_AXI_ARVALID), 32'(!wr && aw_hs < 0));
            chk("bready", 32'(bus.M_AXI_BREADY), 32'(wr && ph == 2));
            chk("rready", 32'(bus.M_AXI_RREADY), 32'(!wr && ph == 2));
            if (wr && aw_hs < 0) chk("awaddr", bus.M_AXI_AWADDR, addr);
            if (wr && w_hs < 0) begin
               chk("wdata", bus.M_AXI_WDATA, wdata);
               chk("wstrb", 32'(bus.M_AXI_WSTRB), 32'(strb));
            end
            if (!wr && aw_hs < 0) chk("araddr", bus.M_AXI_ARADDR, addr);
            chk("rsp_valid", 32'(rsp_valid), 32'(ph == 0));
            if (ph == 0) begin
               if (rsp_k < 0) rsp_k = k;
               chk("rsp_write", 32'(rsp_write), 32'(wr));
               chk("rsp_resp", 32'(rsp_resp), 32'(resp));
               chk("rsp_rdata", rsp_rdata, wr ? 32'h0 : rdata);
            end
            // A wait phase lasting TO cycles raises the flag from the next cycle on.
            if (ph != 0) begin
               ph_cnt = (ph == prev_ph) ? ph_cnt + 1 : 1;
               if (ph_cnt == TO) exp_to = 1'b1;
            end
            prev_ph = ph;
            bus.M_AXI_AWREADY = wr && aw_hs < 0 && k >= 1 + a_dly;
            bus.M_AXI_WREADY  = wr && w_hs < 0 && k >= 1 + w_dly;
            bus.M_AXI_ARREADY = !wr && aw_hs < 0 && k >= 1 + a_dly;
            bus.M_AXI_BVALID  = wr && ph == 2 && k >= last_hs + 1 + r_dly;
            bus.M_AXI_RVALID  = !wr && ph == 2 && k >= last_hs + 1 + r_dly;
            bus.M_AXI_BRESP   = resp;
            bus.M_AXI_RRESP   = resp;
            bus.M_AXI_RDATA   = bus.M_AXI_RVALID ? rdata : $urandom;
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) aw_hs = k;
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) w_hs = k;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) aw_hs = k;
            if ((bus.M_AXI_BVALID && bus.M_AXI_BREADY) || (bus.M_AXI_RVALID && bus.M_AXI_RREADY))
               r_hs = k;
            // Commands presented mid-transaction must be ignored.
            if (junk) begin
               cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
            end else begin
               cmd_valid = 1'b0;
            end
            if (ph == 0) begin
               rsp_ready = (k >= rsp_k + hold);
               if (rsp_ready) begin
                  rsp_hs = k;
                  cmd_valid = 1'b0;
               end
            end
         end
      end
      chk("txn_finished", 32'(fin), 32'd1);
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      slave_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: observed no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      int lat;
      bit wr;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; rsp_ready = 1'b0; exp_to = 1'b0;
      slave_idle();
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 32'd0);
      chk("rst_readies", 32'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_write, rsp_resp}), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
      #1 chk("release_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("started_cmd_ready", 32'(cmd_ready), 32'd1);

      // Zero-wait write to the {last, run, matw} register.
      run_txn(1'b1, 32'h000, 32'h0000_0002, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0, lat);
      chk("wr_latency", 32'(lat), 32'd3);
      // W accepted three cycles before AW.
      run_txn(1'b1, 32'h010, 32'h1234_5678, 4'h3, 3, 0, 0, 2'b00, 32'h0, 0, 1'b1, lat);
      chk("split_latency", 32'(lat), 32'd6);
      // Read of the control register, two-cycle responder, response held 5 cycles.
      run_txn(1'b0, 32'h010, 32'h0, 4'h0, 0, 0, 1, 2'b00, 32'hDEAD_BEEF, 5, 1'b0, lat);
      chk("rd_latency", 32'(lat), 32'd4);
      // Error response passes through, then a normal read.
      run_txn(1'b1, 32'h000, 32'hA5A5_0001, 4'hF, 0, 1, 2, 2'b10, 32'h0, 1, 1'b0, lat);
      run_txn(1'b0, 32'h000, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'h0000_0007, 0, 1'b0, lat);

      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         run_txn(wr, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), lat);
      end
      chk("no_timeout_yet", 32'(timeout), 32'd0);

      // ARREADY withheld past the watchdog limit; transaction still completes.
      run_txn(1'b0, 32'h010, 32'h0, 4'h0, 10, 0, 0, 2'b00, 32'h0BAD_F00D, 0, 1'b0, lat);
      chk("timeout_sticky", 32'(timeout), 32'd1);

      // Reset while AW/W are outstanding.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pre_rst_awvalid", 32'(bus.M_AXI_AWVALID), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID}), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("mid_rst_timeout", 32'(timeout), 32'd0);
      exp_to = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rerelease_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("restart_cmd_ready", 32'(cmd_ready), 32'd1);
      run_txn(1'b1, 32'h000, 32'h0000_0003, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0, lat);
      chk("recover_latency", 32'(lat), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
